// File: rtl/ram_mult_seq.sv
// Sequencer that feeds operand pairs from the nibble RAM to the 4x4 multiplier and writes each
// product back as two nibbles. Optional WAIT timeout with sticky err: define RAM_MULT_SEQ_TIMEOUT_EN.
module ram_mult_seq #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [ADDR_W-1:0]   count,
    output logic                busy,
    output logic                done,
`ifdef RAM_MULT_SEQ_TIMEOUT_EN
    output logic                err,
`endif
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                m_start,
    output logic [DATA_W-1:0]   m_a,
    output logic [DATA_W-1:0]   m_b,
    input  logic [2*DATA_W-1:0] m_res,
    input  logic                m_ready
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_START,
        S_GUARD,
        S_WAIT,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] PAIR_ONE = 1;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   src_r;
    logic [ADDR_W-1:0]   dst_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W:0]     pair_idx;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [2*DATA_W-1:0] res_r;

    logic [ADDR_W-1:0]   pair_off;
    logic [ADDR_W-1:0]   src_a;
    logic [ADDR_W-1:0]   src_b;
    logic [ADDR_W-1:0]   dst_lo;
    logic [ADDR_W-1:0]   dst_hi;
    logic                last_pair;
    logic                timeout_hit;

    // Each pair occupies two words; the shift drops the top bit so regions wrap modulo 2^ADDR_W.
    assign pair_off  = pair_idx[ADDR_W-1:0] << 1;
    assign src_a     = src_r + pair_off;
    assign src_b     = src_a + ADDR_W'(1);
    assign dst_lo    = dst_r + pair_off;
    assign dst_hi    = dst_lo + ADDR_W'(1);
    assign last_pair = (pair_idx + PAIR_ONE) == {1'b0, cnt_r};

    always_comb begin
        // NOTE: next state defaults to the current state so no path through the case infers a latch.
        state_nx = state;
        unique case (state)
            S_IDLE:  if (go) state_nx = S_RD_A;
            S_RD_A:  state_nx = (cnt_r == '0) ? S_DONE : S_RD_B;
            S_RD_B:  state_nx = S_START;
            S_START: state_nx = S_GUARD;
            S_GUARD: state_nx = S_WAIT;
            S_WAIT: begin
                if (m_ready)          state_nx = S_WR_LO;
                else if (timeout_hit) state_nx = S_DONE;
            end
            S_WR_LO: state_nx = S_WR_HI;
            S_WR_HI: state_nx = last_pair ? S_DONE : S_RD_A;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decode straight from state, so an asynchronous reset clears them in the same instant.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            S_RD_A:  ram_addr = src_a;
            S_RD_B:  ram_addr = src_b;
            S_WR_LO: begin
                ram_addr  = dst_lo;
                ram_wdata = res_r[DATA_W-1:0];
            end
            S_WR_HI: begin
                ram_addr  = dst_hi;
                ram_wdata = res_r[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign m_start = (state == S_START);
    assign ram_we  = (state == S_WR_LO) || (state == S_WR_HI);
    assign m_a     = a_r;
    // b arrives on ram_rdata during START itself; forward it so the operand is valid with m_start.
    assign m_b     = (state == S_START) ? ram_rdata : b_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            src_r    <= '0;
            dst_r    <= '0;
            cnt_r    <= '0;
            pair_idx <= '0;
            a_r      <= '0;
            b_r      <= '0;
            res_r    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        src_r    <= src_base;
                        dst_r    <= dst_base;
                        cnt_r    <= count;
                        pair_idx <= '0;
                    end
                end
                S_RD_B:  a_r <= ram_rdata;
                S_START: b_r <= ram_rdata;
                S_WAIT:  if (m_ready) res_r <= m_res;
                S_WR_HI: pair_idx <= pair_idx + PAIR_ONE;
                default: ;
            endcase
        end
    end

`ifdef RAM_MULT_SEQ_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT + 1);

    logic [WC_W-1:0] wait_cnt;

    assign timeout_hit = (state == S_WAIT) && !m_ready && (wait_cnt == WC_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + WC_W'(1) : '0;
            if (state == S_IDLE && go) err <= 1'b0;
            else if (timeout_hit)      err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    a_start_single: assert property (@(posedge clk) disable iff (!reset) m_start |=> !m_start);
    a_timeout_positive: assert property (@(posedge clk) TIMEOUT > 0);

endmodule
